// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the buffered UART receiver: parity modes, FSM states
// and the parity acceptance rule.
package uart_rx_fifo_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // all_xor is ^{data, parity_bit}; odd parity wants 1, even parity wants 0.
  function automatic logic parity_ok(input int mode, input logic all_xor);
    return (mode == PARITY_ODD) ? all_xor : !all_xor;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_fifo.sv
// Show-ahead synchronous FIFO: the head word is presented on data while !empty.
// A pop on an empty FIFO is ignored; a push on a full FIFO is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_BITS:0]   count
);

  localparam logic [DEPTH_BITS:0] DEPTH = (DEPTH_BITS + 1)'(1 << DEPTH_BITS);

  logic [WIDTH-1:0]      mem [2**DEPTH_BITS];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;
  logic [DEPTH_BITS:0]   count_next;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign data    = mem[rd_ptr];

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count;
    if (do_push && !do_pop)      count_next = count + 1'b1;
    else if (do_pop && !do_push) count_next = count - 1'b1;
  end

  // Storage write port.
  // NOTE: the storage array has no reset; emptiness is tracked by the pointers
  // and count, so resetting it would only cost flops and reset routing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and registered status flags; pointers wrap modulo the depth.
  // NOTE: every sequential assignment is non-blocking so all registers update
  // from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == DEPTH);
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable framing, a receive FIFO and sticky error flags.
// Holds the rx synchroniser, bit timer, frame FSM, shift register and error flags;
// received words are buffered in sync_fifo for the CPU to pop with rd.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLOCK_DIV          = 8,
  parameter int CLOCK_COUNTER_BITS = 4,
  parameter int DATA_BITS          = 8,
  parameter int PARITY             = 0,
  parameter int STOP_BITS          = 1,
  parameter int FIFO_DEPTH_BITS    = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx,
  input  logic                       rd,
  output logic [DATA_BITS-1:0]       data,
  output logic                       empty,
  output logic                       full,
  output logic [FIFO_DEPTH_BITS:0]   count,
  output logic                       err_frame,
  output logic                       err_parity,
  output logic                       err_overrun,
  input  logic                       err_clear,
  output logic                       interrupt
);

  localparam logic [CLOCK_COUNTER_BITS-1:0] HALF_LAST = CLOCK_COUNTER_BITS'(CLOCK_DIV / 2 - 1);
  localparam logic [CLOCK_COUNTER_BITS-1:0] BIT_LAST  = CLOCK_COUNTER_BITS'(CLOCK_DIV - 1);
  localparam logic [3:0]                    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic                          STOP_LAST = 1'(STOP_BITS - 1);

  rx_state_e                     state;
  rx_state_e                     state_next;
  logic                          rx_meta;
  logic                          rx_sync;
  logic [CLOCK_COUNTER_BITS-1:0] timer;
  logic [3:0]                    bit_cnt;
  logic                          stop_cnt;
  logic [DATA_BITS-1:0]          shreg;
  logic                          par_bad;

  // FSM strobes
  logic timer_clr;
  logic shift_en;
  logic par_sample;
  logic stop_sample;
  logic frame_bad;
  logic word_done;

  logic word_ok;
  logic push;
  logic overrun_set;
  logic parity_set;

  // Two-flop synchroniser for the asynchronous rx pin; idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic and per-cycle strobes for the datapath.
  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    timer_clr   = 1'b0;
    shift_en    = 1'b0;
    par_sample  = 1'b0;
    stop_sample = 1'b0;
    frame_bad   = 1'b0;
    word_done   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!rx_sync) begin
          state_next = ST_START;
          timer_clr  = 1'b1;
        end
      end
      ST_START: begin
        if (timer == HALF_LAST) begin
          timer_clr  = 1'b1;
          state_next = rx_sync ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (timer == BIT_LAST) begin
          timer_clr = 1'b1;
          shift_en  = 1'b1;
          if (bit_cnt == DATA_LAST)
            state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (timer == BIT_LAST) begin
          timer_clr  = 1'b1;
          par_sample = 1'b1;
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (timer == BIT_LAST) begin
          timer_clr   = 1'b1;
          stop_sample = 1'b1;
          if (!rx_sync) begin
            frame_bad  = 1'b1;
            state_next = ST_BREAK;
          end else if (stop_cnt == STOP_LAST) begin
            word_done  = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      ST_BREAK: begin
        if (rx_sync) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Bit timer, bit counters, shift register and pending parity failure.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      par_bad  <= 1'b0;
    end else begin
      timer <= timer_clr ? '0 : timer + 1'b1;
      if (state == ST_IDLE) begin
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
        par_bad  <= 1'b0;
      end else begin
        if (shift_en)    bit_cnt  <= bit_cnt + 1'b1;
        if (stop_sample) stop_cnt <= stop_cnt + 1'b1;
        if (parity_set)  par_bad  <= 1'b1;
      end
      if (shift_en) shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
    end
  end

  assign parity_set  = par_sample && !parity_ok(PARITY, ^{shreg, rx_sync});
  assign word_ok     = word_done && !par_bad;
  assign push        = word_ok && (!full || rd);
  assign overrun_set = word_ok && full && !rd;

  // Sticky error flags; a new event in the same cycle beats err_clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_frame   <= 1'b0;
      err_parity  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (frame_bad)        err_frame <= 1'b1;
      else if (err_clear)   err_frame <= 1'b0;
      if (parity_set)       err_parity <= 1'b1;
      else if (err_clear)   err_parity <= 1'b0;
      if (overrun_set)      err_overrun <= 1'b1;
      else if (err_clear)   err_overrun <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH      (DATA_BITS),
    .DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (shreg),
    .pop       (rd),
    .data      (data),
    .empty     (empty),
    .full      (full),
    .count     (count)
  );

  assign interrupt = !empty || err_frame || err_parity || err_overrun;

endmodule
